// File: rtl/simmem_bank_scheduler_if.sv
// Request/completion bus of one simulated DRAM bank scheduler.
interface simmem_bank_scheduler_if #(
    parameter int unsigned RowIdW = 9,
    parameter int unsigned WIidW  = 2,
    parameter int unsigned RIidW  = 1
);
    localparam int unsigned IidW = (WIidW > RIidW) ? WIidW : RIidW;

    logic              w_valid_i;
    logic              w_ready_o;
    logic [RowIdW-1:0] w_row_i;
    logic [WIidW-1:0]  w_iid_i;
    logic              r_valid_i;
    logic              r_ready_o;
    logic [RowIdW-1:0] r_row_i;
    logic [RIidW-1:0]  r_iid_i;
    logic              done_valid_o;
    logic              done_ready_i;
    logic              done_type_o;
    logic [IidW-1:0]   done_iid_o;

    modport master (
        output w_valid_i, w_row_i, w_iid_i, r_valid_i, r_row_i, r_iid_i, done_ready_i,
        input  w_ready_o, r_ready_o, done_valid_o, done_type_o, done_iid_o
    );

    modport slave (
        input  w_valid_i, w_row_i, w_iid_i, r_valid_i, r_row_i, r_iid_i, done_ready_i,
        output w_ready_o, r_ready_o, done_valid_o, done_type_o, done_iid_o
    );
endinterface

// File: rtl/simmem_bank_scheduler.sv
// Single-bank DRAM access sequencer: round-robin write/read grant, open-row cost model, delay count.
// Optional SIMMEM_CLOSED_PAGE_EN: closed-page policy with a PRECHARGE state after each completion.
module simmem_bank_scheduler #(
    parameter int unsigned RowIdW  = 9,
    parameter int unsigned WIidW   = 2,
    parameter int unsigned RIidW   = 1,
    parameter int unsigned HitCost = 4,
    parameter int unsigned PreCost = 2,
    parameter int unsigned ActCost = 1,
    parameter int unsigned CntW    = $clog2(HitCost + PreCost + ActCost + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    simmem_bank_scheduler_if.slave    bus,
    output logic                      row_open_o,
    output logic [RowIdW-1:0]         open_row_o
);
    localparam int unsigned IidW = (WIidW > RIidW) ? WIidW : RIidW;
    localparam logic [CntW-1:0] HitC   = CntW'(HitCost);
    localparam logic [CntW-1:0] EmptyC = CntW'(ActCost + HitCost);
    localparam logic [CntW-1:0] ConfC  = CntW'(PreCost + ActCost + HitCost);
`ifdef SIMMEM_CLOSED_PAGE_EN
    localparam logic [CntW-1:0] PreLoad = CntW'((PreCost > 0) ? PreCost - 1 : 0);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE,
`ifdef SIMMEM_CLOSED_PAGE_EN
        ST_PRECHARGE,
`endif
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              tok_w_q, tok_w_d;
    logic              en_q, en_d;
    logic              row_open_q, row_open_d;
    logic [RowIdW-1:0] open_row_q, open_row_d;
    logic              done_valid_q, done_valid_d;
    logic              done_type_q, done_type_d;
    logic [IidW-1:0]   done_iid_q, done_iid_d;
    logic              w_rdy, r_rdy, grant_w, grant_r;
    logic [RowIdW-1:0] req_row;
    logic [CntW-1:0]   cost;

    // Next-state, arbitration and cost selection
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tok_w_d      = tok_w_q;
        en_d         = 1'b1;
        row_open_d   = row_open_q;
        open_row_d   = open_row_q;
        done_valid_d = done_valid_q;
        done_type_d  = done_type_q;
        done_iid_d   = done_iid_q;
        w_rdy        = 1'b0;
        r_rdy        = 1'b0;
        grant_w      = 1'b0;
        grant_r      = 1'b0;
        req_row      = '0;
        cost         = '0;
        unique case (state_q)
            ST_IDLE: begin
                // Write wins unless a read is valid and write either lacks the token or is idle.
                w_rdy   = en_q & ~(bus.r_valid_i & (~tok_w_q | ~bus.w_valid_i));
                r_rdy   = en_q & bus.r_valid_i & ~w_rdy;
                grant_w = w_rdy & bus.w_valid_i;
                grant_r = r_rdy & bus.r_valid_i;
                if (grant_w | grant_r) begin
                    req_row = grant_w ? bus.w_row_i : bus.r_row_i;
                    if (!row_open_q)                cost = EmptyC;
                    else if (open_row_q == req_row) cost = HitC;
                    else                            cost = ConfC;
                    tok_w_d     = grant_r;
                    row_open_d  = 1'b1;
                    open_row_d  = req_row;
                    done_type_d = grant_r;
                    done_iid_d  = grant_w ? IidW'(bus.w_iid_i) : IidW'(bus.r_iid_i);
                    cnt_d       = cost - CntW'(1);
                    if (cnt_d == '0) begin
                        state_d      = ST_DONE;
                        done_valid_d = 1'b1;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end
            end
            ST_SERVE: begin
                cnt_d = (cnt_q != '0) ? cnt_q - CntW'(1) : '0;
                if (cnt_d == '0) begin
                    state_d      = ST_DONE;
                    done_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.done_ready_i) begin
                    done_valid_d = 1'b0;
`ifdef SIMMEM_CLOSED_PAGE_EN
                    if (PreCost > 0) begin
                        state_d = ST_PRECHARGE;
                        cnt_d   = PreLoad;
                    end else begin
                        state_d    = ST_IDLE;
                        row_open_d = 1'b0;
                        open_row_d = '0;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef SIMMEM_CLOSED_PAGE_EN
            ST_PRECHARGE: begin
                if (cnt_q == '0) begin
                    state_d    = ST_IDLE;
                    row_open_d = 1'b0;
                    open_row_d = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tok_w_q      <= 1'b1;
            en_q         <= 1'b0;
            row_open_q   <= 1'b0;
            open_row_q   <= '0;
            done_valid_q <= 1'b0;
            done_type_q  <= 1'b0;
            done_iid_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tok_w_q      <= tok_w_d;
            en_q         <= en_d;
            row_open_q   <= row_open_d;
            open_row_q   <= open_row_d;
            done_valid_q <= done_valid_d;
            done_type_q  <= done_type_d;
            done_iid_q   <= done_iid_d;
        end
    end

    assign bus.w_ready_o    = w_rdy;
    assign bus.r_ready_o    = r_rdy;
    assign bus.done_valid_o = done_valid_q;
    assign bus.done_type_o  = done_type_q;
    assign bus.done_iid_o   = done_iid_q;
    assign row_open_o       = row_open_q;
    assign open_row_o       = open_row_q;

    a_one_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.w_ready_o && bus.r_ready_o));
    a_w_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.w_valid_i && !bus.w_ready_o) |=>
        (bus.w_valid_i && $stable(bus.w_row_i) && $stable(bus.w_iid_i)));
    a_r_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.r_valid_i && !bus.r_ready_o) |=>
        (bus.r_valid_i && $stable(bus.r_row_i) && $stable(bus.r_iid_i)));
endmodule

// File: tb/tb_simmem_bank_scheduler.sv
// Directed bench for simmem_bank_scheduler; expectations follow SIMMEM_CLOSED_PAGE_EN when defined.
module tb_simmem_bank_scheduler;
    localparam int unsigned RowIdW = 9;
    localparam int unsigned WIidW  = 2;
    localparam int unsigned RIidW  = 1;
`ifdef SIMMEM_CLOSED_PAGE_EN
    localparam bit CLOSED = 1'b1;
`else
    localparam bit CLOSED = 1'b0;
`endif
    localparam int PRE_GAP  = CLOSED ? 2 : 0;
    localparam int EXP_EMP  = 5;
    localparam int EXP_HIT  = CLOSED ? 5 : 4;
    localparam int EXP_CONF = CLOSED ? 5 : 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    simmem_bank_scheduler_if #(.RowIdW(RowIdW), .WIidW(WIidW), .RIidW(RIidW)) bus ();
    logic              row_open;
    logic [RowIdW-1:0] open_row;

    simmem_bank_scheduler dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus),
        .row_open_o (row_open),
        .open_row_o (open_row)
    );

    int checks = 0;
    int errors = 0;
    int lat;
    bit seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_w_ready"},    32'(bus.w_ready_o),    0);
        chk({tag, "_r_ready"},    32'(bus.r_ready_o),    0);
        chk({tag, "_done_valid"}, 32'(bus.done_valid_o), 0);
        chk({tag, "_done_type"},  32'(bus.done_type_o),  0);
        chk({tag, "_done_iid"},   32'(bus.done_iid_o),   0);
        chk({tag, "_row_open"},   32'(row_open),         0);
        chk({tag, "_open_row"},   32'(open_row),         0);
    endtask

    // Count negedges from the grant cycle until done_valid_o is seen.
    task automatic wait_done(output int n);
        n = 1;
        while (!bus.done_valid_o && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic issue(input bit is_w, input int row, input int iid, output int n);
        bit acc;
        int tries;
        if (is_w) begin
            bus.w_valid_i = 1'b1; bus.w_row_i = RowIdW'(row); bus.w_iid_i = WIidW'(iid);
        end else begin
            bus.r_valid_i = 1'b1; bus.r_row_i = RowIdW'(row); bus.r_iid_i = RIidW'(iid);
        end
        tries = 0;
        #1 acc = is_w ? bus.w_ready_o : bus.r_ready_o;
        while (!acc && tries < 40) begin
            @(negedge clk);
            #1 acc = is_w ? bus.w_ready_o : bus.r_ready_o;
            tries++;
        end
        chk(is_w ? "w_accept" : "r_accept", 32'(acc), 1);
        @(negedge clk);
        if (is_w) bus.w_valid_i = 1'b0; else bus.r_valid_i = 1'b0;
        wait_done(n);
    endtask

    task automatic done_hs();
        bus.done_ready_i = 1'b1;
        @(negedge clk);
        bus.done_ready_i = 1'b0;
        chk("done_drop", 32'(bus.done_valid_o), 0);
    endtask

    // Walk through any precharge cycles; readies must stay low there.
    task automatic settle();
        for (int i = 0; i < PRE_GAP; i++) begin
            #1 chk("pre_w_ready", 32'(bus.w_ready_o), 0);
            chk("pre_r_ready", 32'(bus.r_ready_o), 0);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.w_valid_i = 1'b0; bus.w_row_i = '0; bus.w_iid_i = '0;
        bus.r_valid_i = 1'b0; bus.r_row_i = '0; bus.r_iid_i = '0;
        bus.done_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: write to empty bank
        issue(1'b1, 5, 2, lat);
        chk("t1_latency", 32'(lat), EXP_EMP);
        chk("t1_type", 32'(bus.done_type_o), 0);
        chk("t1_iid", 32'(bus.done_iid_o), 2);
        chk("t1_row_open", 32'(row_open), 1);
        chk("t1_open_row", 32'(open_row), 5);
        chk("t1_done_w_ready", 32'(bus.w_ready_o), 0);
        done_hs();
        settle();
        chk("t1_row_after", 32'(row_open), CLOSED ? 0 : 1);

        // Test 2: read to the same row
        issue(1'b0, 5, 1, lat);
        chk("t2_latency", 32'(lat), EXP_HIT);
        chk("t2_type", 32'(bus.done_type_o), 1);
        chk("t2_iid", 32'(bus.done_iid_o), 1);
        done_hs();
        settle();

        // Test 3: write to another row
        issue(1'b1, 9, 3, lat);
        chk("t3_latency", 32'(lat), EXP_CONF);
        chk("t3_open_row", 32'(open_row), 9);
        chk("t3_row_open", 32'(row_open), 1);
        done_hs();
        settle();
        chk("t3_row_after", 32'(row_open), CLOSED ? 0 : 1);
        chk("t3_open_after", 32'(open_row), CLOSED ? 0 : 9);

        // Test 4/5: both ports valid, alternation and done back-pressure
        do_reset();
        bus.w_valid_i = 1'b1; bus.w_row_i = 9'd7; bus.w_iid_i = 2'd1;
        bus.r_valid_i = 1'b1; bus.r_row_i = 9'd7; bus.r_iid_i = 1'd1;
        #1 chk("t4_w_first", 32'(bus.w_ready_o), 1);
        chk("t4_r_wait", 32'(bus.r_ready_o), 0);
        @(negedge clk);
        bus.w_valid_i = 1'b0;
        wait_done(lat);
        chk("t4_w_latency", 32'(lat), EXP_EMP);
        chk("t4_w_type", 32'(bus.done_type_o), 0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_hold_valid", 32'(bus.done_valid_o), 1);
            chk("t5_hold_type", 32'(bus.done_type_o), 0);
            chk("t5_hold_iid", 32'(bus.done_iid_o), 1);
            chk("t5_hold_w_ready", 32'(bus.w_ready_o), 0);
            chk("t5_hold_r_ready", 32'(bus.r_ready_o), 0);
            @(negedge clk);
        end
        done_hs();
        settle();
        bus.w_valid_i = 1'b1; bus.w_row_i = 9'd7; bus.w_iid_i = 2'd2;
        #1 chk("t4_r_second", 32'(bus.r_ready_o), 1);
        chk("t4_w_blocked", 32'(bus.w_ready_o), 0);
        @(negedge clk);
        bus.r_valid_i = 1'b0;
        wait_done(lat);
        chk("t4_r_latency", 32'(lat), EXP_HIT);
        chk("t4_r_type", 32'(bus.done_type_o), 1);
        chk("t4_r_iid", 32'(bus.done_iid_o), 1);
        done_hs();
        settle();
        #1 chk("t4_w_third", 32'(bus.w_ready_o), 1);
        @(negedge clk);
        bus.w_valid_i = 1'b0;
        wait_done(lat);
        chk("t4_w2_latency", 32'(lat), EXP_HIT);
        chk("t4_w2_type", 32'(bus.done_type_o), 0);
        chk("t4_w2_iid", 32'(bus.done_iid_o), 2);
        done_hs();
        settle();

        // Test 6: reset during a long access
        do_reset();
        issue(1'b1, 3, 0, lat);
        chk("t6_first_latency", 32'(lat), EXP_EMP);
        done_hs();
        settle();
        bus.w_valid_i = 1'b1; bus.w_row_i = 9'd4; bus.w_iid_i = 2'd1;
        #1 chk("t6_accept", 32'(bus.w_ready_o), 1);
        @(negedge clk);
        bus.w_valid_i = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("t6_midreset");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done_valid_o) seen = 1'b1;
        end
        chk("t6_no_done", 32'(seen), 0);
        bus.w_valid_i = 1'b1; bus.w_row_i = 9'd4; bus.w_iid_i = 2'd1;
        bus.r_valid_i = 1'b1; bus.r_row_i = 9'd4; bus.r_iid_i = 1'd0;
        #1 chk("t6_token_w", 32'(bus.w_ready_o), 1);
        chk("t6_token_r", 32'(bus.r_ready_o), 0);
        @(negedge clk);
        bus.w_valid_i = 1'b0;
        wait_done(lat);
        chk("t6_after_latency", 32'(lat), EXP_EMP);
        done_hs();
        settle();
        #1 chk("t6_r_next", 32'(bus.r_ready_o), 1);
        @(negedge clk);
        bus.r_valid_i = 1'b0;
        wait_done(lat);
        chk("t6_r_latency", 32'(lat), EXP_HIT);
        done_hs();
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
